// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: ALU op codes,
// RV32I major opcodes and the issue FSM state encoding.
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_XOR = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_BLT = 4'b1010;
  localparam logic [3:0] ALU_BGE = 4'b1011;
  localparam logic [3:0] ALU_SET = 4'b1100;

  // RV32I major opcodes handled by the execute stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Issue controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: sign-extended I, U, B and J immediates.
// Only inst[31:7] carries immediate bits, so the opcode field is not an input.
module imm_gen (
  input  logic [31:7] inst,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j
);

  // Pure bit rearrangement with sign extension from inst[31]
  always_comb begin
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_u = {inst[31:12], 12'b0};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller: decodes one RV32I instruction, issues it to the
// ALU, waits for the completion pulse and presents writeback / redirect data.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its payload stable until that edge; ready
// may change freely. in_ready is high only in IDLE, out_valid only in RESP.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ctrl_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_sub,
  output logic        alu_sign,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  input  logic        alu_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rd_addr,
  output logic        rd_wen,
  output logic [31:0] rd_data,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        illegal,
  output state_t      fsm_state
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, imm_b, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  imm_gen u_imm_gen (
    .inst  (inst[31:7]),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .imm_b (imm_b),
    .imm_j (imm_j)
  );

  // Decode results, evaluated on the live upstream payload at accept time
  logic [31:0] dec_a, dec_b, dec_target;
  logic [3:0]  dec_ctrl;
  logic        dec_sub, dec_sign, dec_illegal, dec_branch, dec_jump, dec_writes;
  logic        dec_wen;

  // Instruction decode: ALU controls, operand selection and local target adder
  always_comb begin
    dec_a       = rs1_data;
    dec_b       = rs2_data;
    dec_ctrl    = ALU_ADD;
    dec_sub     = 1'b0;
    dec_sign    = 1'b0;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_writes  = 1'b0;
    dec_target  = pc + imm_b;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_writes = 1'b1;
        if (opcode == OPC_OP_IMM) dec_b = imm_i;
        case (funct3)
          3'b000: dec_sub = (opcode == OPC_OP) & inst[30];
          3'b001: dec_ctrl = ALU_SLL;
          3'b010: begin dec_ctrl = ALU_SET; dec_sub = 1'b1; dec_sign = 1'b1; end
          3'b011: begin dec_ctrl = ALU_SET; dec_sub = 1'b1; end
          3'b100: dec_ctrl = ALU_XOR;
          3'b101: dec_ctrl = inst[30] ? ALU_SRA : ALU_SRL;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        dec_sub    = 1'b1;
        dec_branch = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = ALU_BEQ;
          3'b001:  dec_ctrl = ALU_BNE;
          3'b100:  begin dec_ctrl = ALU_BLT; dec_sign = 1'b1; end
          3'b101:  begin dec_ctrl = ALU_BGE; dec_sign = 1'b1; end
          3'b110:  dec_ctrl = ALU_BLT;
          3'b111:  dec_ctrl = ALU_BGE;
          default: begin dec_illegal = 1'b1; dec_branch = 1'b0; end
        endcase
      end
      OPC_LUI: begin
        dec_a      = 32'd0;
        dec_b      = imm_u;
        dec_writes = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a      = pc;
        dec_b      = imm_u;
        dec_writes = 1'b1;
      end
      OPC_JAL: begin
        dec_a      = pc;
        dec_b      = 32'd4;
        dec_jump   = 1'b1;
        dec_writes = 1'b1;
        dec_target = pc + imm_j;
      end
      OPC_JALR: begin
        dec_a      = pc;
        dec_b      = 32'd4;
        dec_jump   = 1'b1;
        dec_writes = 1'b1;
        dec_target = (rs1_data + imm_i) & ~32'd1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_wen = dec_writes & (inst[11:7] != 5'd0);

  // Per-instruction context carried from accept to the response
  state_t      state;
  logic        branch_q, jump_q, wen_q;
  logic [4:0]  rd_q;
  logic [31:0] target_q, pc4_q;

  assign fsm_state = state;

  // Issue FSM with all handshake, ALU-request and response outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      ctrl_valid <= 1'b0;
      out_valid  <= 1'b0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_ctrl   <= 4'd0;
      alu_sub    <= 1'b0;
      alu_sign   <= 1'b0;
      rd_addr    <= 5'd0;
      rd_wen     <= 1'b0;
      rd_data    <= 32'd0;
      next_pc    <= RESET_PC;
      redirect   <= 1'b0;
      illegal    <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      wen_q      <= 1'b0;
      rd_q       <= 5'd0;
      target_q   <= 32'd0;
      pc4_q      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            branch_q <= dec_branch;
            jump_q   <= dec_jump;
            wen_q    <= dec_wen;
            rd_q     <= inst[11:7];
            target_q <= dec_target;
            pc4_q    <= pc + 32'd4;
            if (dec_illegal) begin
              // No ALU round trip: respond immediately with a fall-through PC
              state     <= ST_RESP;
              out_valid <= 1'b1;
              illegal   <= 1'b1;
              rd_addr   <= inst[11:7];
              rd_wen    <= 1'b0;
              rd_data   <= 32'd0;
              redirect  <= 1'b0;
              next_pc   <= pc + 32'd4;
            end else begin
              state      <= ST_ISSUE;
              ctrl_valid <= 1'b1;
              alu_a      <= dec_a;
              alu_b      <= dec_b;
              alu_ctrl   <= dec_ctrl;
              alu_sub    <= dec_sub;
              alu_sign   <= dec_sign;
            end
          end
        end
        ST_ISSUE: begin
          ctrl_valid <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_valid) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            illegal   <= 1'b0;
            rd_addr   <= rd_q;
            rd_wen    <= wen_q;
            rd_data   <= alu_result;
            redirect  <= branch_q ? alu_branch : jump_q;
            next_pc   <= (branch_q ? alu_branch : jump_q) ? target_q : pc4_q;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the request side, RV32I-level
// reference model for the response side, directed plus random instructions.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = 32'd0, pc = 32'd0, rs1_data = 32'd0, rs2_data = 32'd0;
  logic        ctrl_valid;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_sub, alu_sign;
  logic [31:0] alu_result = 32'd0;
  logic        alu_branch = 1'b0;
  logic        alu_valid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [31:0] rd_data, next_pc;
  logic        redirect, illegal;
  state_t      fsm_state;

  alu_issue_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ctrl_valid(ctrl_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_sub(alu_sub), .alu_sign(alu_sign),
    .alu_result(alu_result), .alu_branch(alu_branch), .alu_valid(alu_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .rd_data(rd_data),
    .next_pc(next_pc), .redirect(redirect), .illegal(illegal),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural ALU ----------------
  function automatic logic alu_lt(logic [31:0] a, logic [31:0] b, logic sign);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    return sign ? (sa < sb) : (a < b);
  endfunction

  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                        logic sub, logic sign);
    logic signed [31:0] sa;
    sa = a;
    case (c)
      4'b0000: return sub ? a - b : a + b;
      4'b0001: return a ^ b;
      4'b0010: return a | b;
      4'b0011: return a & b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return sa >>> b[4:0];
      4'b1100: return {31'd0, alu_lt(a, b, sign)};
      default: return a + b;
    endcase
  endfunction

  function automatic logic br_f(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic sign);
    case (c)
      4'b1000: return a == b;
      4'b1001: return a != b;
      4'b1010: return alu_lt(a, b, sign);
      4'b1011: return !alu_lt(a, b, sign);
      default: return 1'b0;
    endcase
  endfunction

  logic        alu_mute = 1'b0;
  logic        late_req = 1'b0;
  logic [3:0]  cap_ctrl = 4'd0;
  logic [31:0] cap_a = 32'd0, cap_b = 32'd0;
  logic        cap_sub = 1'b0, cap_sign = 1'b0;
  int          n_ctrl = 0;

  // ALU: latch on ctrl_valid, answer one cycle later
  always @(posedge clock) begin
    alu_valid <= 1'b0;
    if (ctrl_valid) begin
      cap_ctrl <= alu_ctrl;
      cap_a    <= alu_a;
      cap_b    <= alu_b;
      cap_sub  <= alu_sub;
      cap_sign <= alu_sign;
      n_ctrl   <= n_ctrl + 1;
      if (!alu_mute) begin
        alu_valid  <= 1'b1;
        alu_result <= alu_f(alu_ctrl, alu_a, alu_b, alu_sub, alu_sign);
        alu_branch <= br_f(alu_ctrl, alu_a, alu_b, alu_sign);
      end
    end
    if (late_req) begin
      alu_valid  <= 1'b1;
      alu_result <= 32'hdead_beef;
      alu_branch <= 1'b1;
    end
  end

  // ---------------- RV32I reference model ----------------
  typedef struct {
    logic        ill;
    logic        wen;
    logic        redir;
    logic        wb_check;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] npc;
  } ref_t;

  function automatic ref_t ref_exec(logic [31:0] w, logic [31:0] p,
                                    logic [31:0] r1, logic [31:0] r2);
    ref_t r;
    logic [31:0] i_imm, u_imm, b_imm, j_imm, b;
    logic signed [31:0] s1, sb;
    logic [4:0] sh;
    logic t;
    i_imm = {{20{w[31]}}, w[31:20]};
    u_imm = {w[31:12], 12'd0};
    b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    r.ill = 1'b0; r.wen = 1'b0; r.redir = 1'b0; r.wb_check = 1'b1;
    r.rd = w[11:7]; r.data = 32'd0; r.npc = p + 32'd4;
    t = 1'b0;
    s1 = r1;
    case (w[6:0])
      7'h33, 7'h13: begin
        b  = (w[6:0] == 7'h33) ? r2 : i_imm;
        sb = b;
        sh = b[4:0];
        case (w[14:12])
          3'd0: r.data = (w[6:0] == 7'h33 && w[30]) ? r1 - b : r1 + b;
          3'd1: r.data = r1 << sh;
          3'd2: r.data = (s1 < sb) ? 32'd1 : 32'd0;
          3'd3: r.data = (r1 < b) ? 32'd1 : 32'd0;
          3'd4: r.data = r1 ^ b;
          3'd5: r.data = w[30] ? 32'(s1 >>> sh) : r1 >> sh;
          3'd6: r.data = r1 | b;
          3'd7: r.data = r1 & b;
        endcase
        r.wen = (r.rd != 5'd0);
      end
      7'h63: begin
        r.wb_check = 1'b0;
        sb = r2;
        case (w[14:12])
          3'd0: t = (r1 == r2);
          3'd1: t = (r1 != r2);
          3'd4: t = (s1 < sb);
          3'd5: t = (s1 >= sb);
          3'd6: t = (r1 < r2);
          3'd7: t = (r1 >= r2);
          default: r.ill = 1'b1;
        endcase
        if (!r.ill) begin
          r.redir = t;
          r.npc   = t ? p + b_imm : p + 32'd4;
        end
      end
      7'h37: begin r.data = u_imm;     r.wen = (r.rd != 5'd0); end
      7'h17: begin r.data = p + u_imm; r.wen = (r.rd != 5'd0); end
      7'h6f: begin
        r.data = p + 32'd4; r.wen = (r.rd != 5'd0);
        r.redir = 1'b1; r.npc = p + j_imm;
      end
      7'h67: begin
        r.data = p + 32'd4; r.wen = (r.rd != 5'd0);
        r.redir = 1'b1; r.npc = (r1 + i_imm) & 32'hffff_fffe;
      end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) r.wb_check = 1'b0;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4, 5: w[6:0] = 7'h63;
      6:    w[6:0] = 7'h37;
      7:    w[6:0] = 7'h17;
      8:    w[6:0] = w[31] ? 7'h6f : 7'h67;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Push one instruction, follow it to the response, optionally stall the
  // response (with a competing in_valid) and complete the output handshake.
  task automatic issue(input logic [31:0] i_inst, input logic [31:0] i_pc,
                       input logic [31:0] i_rs1, input logic [31:0] i_rs2,
                       input int stall, input bit hold_in);
    ref_t r;
    int lat, waitc, c0;
    r = ref_exec(i_inst, i_pc, i_rs1, i_rs2);
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    inst = i_inst; pc = i_pc; rs1_data = i_rs1; rs2_data = i_rs2;
    in_valid = 1'b1;
    c0 = n_ctrl;
    tick();
    in_valid = 1'b0;
    inst = $urandom; pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      lat++;
    end
    chk("latency", lat, r.ill ? 32'd1 : 32'd3);
    chk("ctrl_pulses", n_ctrl - c0, r.ill ? 32'd0 : 32'd1);
    exp_q.push_back(r.npc);
    for (int s = 0; s <= stall; s++) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
      chk("illegal", {31'd0, illegal}, {31'd0, r.ill});
      chk("rd_wen", {31'd0, rd_wen}, {31'd0, r.wen});
      chk("redirect", {31'd0, redirect}, {31'd0, r.redir});
      chk("next_pc", next_pc, exp_q[0]);
      if (r.wen) chk("rd_addr", {27'd0, rd_addr}, {27'd0, r.rd});
      if (r.wb_check) chk("rd_data", rd_data, r.data);
      if (s < stall) begin
        if (hold_in) begin
          in_valid = 1'b1;
          inst = rand_inst();
        end
        tick();
      end
    end
    chk("no_second_issue", n_ctrl - c0, r.ill ? 32'd0 : 32'd1);
    void'(exp_q.pop_front());
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // Reset while waiting on the ALU, then a stray completion pulse
  task automatic reset_in_wait();
    int c0;
    alu_mute = 1'b1;
    inst = enc_i(12'd7, 5'd2, 3'b000, 5'd9, 7'h13);
    pc = 32'h8000_0100; rs1_data = 32'd3; rs2_data = 32'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c0 = n_ctrl;
    late_req = 1'b1;
    tick();
    late_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    chk("rst_next_pc", next_pc, RESET_PC);
    chk("rst_no_issue", n_ctrl - c0, 32'd0);
    alu_mute = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_ctl", {27'd0, alu_ctrl, alu_sub, alu_sign}, 32'd0);
    chk("reset_rd", {26'd0, rd_addr, rd_wen}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_flags", {30'd0, redirect, illegal}, 32'd0);
    chk("reset_next_pc", next_pc, RESET_PC);

    // ADDI x1, x0, -5
    issue(32'hffb0_0093, 32'h8000_0000, 32'd0, 32'h1234_5678, 0, 1'b0);
    chk("addi_ctrl", {28'd0, cap_ctrl}, 32'd0);
    chk("addi_b", cap_b, 32'hffff_fffb);
    chk("addi_sub", {31'd0, cap_sub}, 32'd0);

    // SUB x3, x1, x2 with 5 - 7
    issue({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h8000_0004, 32'd5, 32'd7, 1, 1'b0);
    chk("sub_ctrl", {28'd0, cap_ctrl}, 32'd0);
    chk("sub_sub", {31'd0, cap_sub}, 32'd1);

    // BLTU 1 < 0xffffffff, offset 16
    issue(enc_b(13'd16, 5'd2, 5'd1, 3'b110), 32'h8000_0000, 32'd1, 32'hffff_ffff, 0, 1'b0);
    chk("bltu_ctrl", {28'd0, cap_ctrl}, 32'b1010);
    chk("bltu_sign", {31'd0, cap_sign}, 32'd0);
    chk("bltu_sub", {31'd0, cap_sub}, 32'd1);

    // JALR x5, 4(x1)
    issue(enc_i(12'd4, 5'd1, 3'b000, 5'd5, 7'h67), 32'h8000_0020, 32'h8000_0103, 32'd0, 0, 1'b0);

    // Illegal opcode (LOAD is not handled here)
    issue(32'h0000_0003, 32'h8000_0040, 32'd0, 32'd0, 0, 1'b0);

    // Long response stall with upstream pressing a new instruction
    issue(enc_i(12'h7ff, 5'd4, 3'b100, 5'd6, 7'h13), 32'h8000_0080, 32'haaaa_5555, 32'd0, 5, 1'b1);

    reset_in_wait();

    for (int n = 0; n < 200; n++) begin
      issue(rand_inst(), $urandom & 32'hffff_fffc, rand_opnd(), rand_opnd(),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
